// File: rtl/hamming_sec_pkg.sv
// Shared constants, FSM state type and the Hamming(12,8) encoder for the SEC array controller.
package hamming_sec_pkg;

   localparam int DATA_W = 8;
   localparam int CODE_W = 12;
   localparam int SYND_W = 4;

   // Codeword bit i carries position i+1
   localparam logic [SYND_W-1:0] PAR_POS  [4]      = '{4'd1, 4'd2, 4'd4, 4'd8};
   localparam logic [SYND_W-1:0] DATA_POS [DATA_W] = '{4'd3, 4'd5, 4'd6, 4'd7,
                                                       4'd9, 4'd10, 4'd11, 4'd12};

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_SCRUB_RD = 2'd1,
      ST_SCRUB_WB = 2'd2
   } state_e;

   // Parity bit at position 2**j is bit j of the XOR of the set data positions
   function automatic logic [CODE_W-1:0] hamming_sec_encode(input logic [DATA_W-1:0] data);
      logic [CODE_W-1:0] cw;
      logic [SYND_W-1:0] acc;
      cw  = {CODE_W{1'b0}};
      acc = {SYND_W{1'b0}};
      for (int i = 0; i < DATA_W; i++) begin
         cw[DATA_POS[i] - 4'd1] = data[i];
         if (data[i]) begin
            acc = acc ^ DATA_POS[i];
         end else begin
            acc = acc;
         end
      end
      for (int j = 0; j < 4; j++) begin
         cw[PAR_POS[j] - 4'd1] = acc[j];
      end
      return cw;
   endfunction

endpackage

// File: rtl/hamming_sec_dec.sv
// Combinational Hamming(12,8) SEC decoder: syndrome, single-bit correction and data extraction.
module hamming_sec_dec
   import hamming_sec_pkg::*;
(
   input  logic [CODE_W-1:0] code_i,
   output logic [DATA_W-1:0] data_o,
   output logic [CODE_W-1:0] code_o,
   output logic [SYND_W-1:0] synd_o,
   output logic              corr_o,
   output logic              uncorr_o
);

   logic [SYND_W-1:0] synd_s;
   logic [CODE_W-1:0] fixed_s;
   logic              corr_s;

   // Syndrome is the XOR of the positions of all set bits
   always_comb begin
      synd_s = {SYND_W{1'b0}};
      for (int i = 0; i < CODE_W; i++) begin
         if (code_i[i]) begin
            synd_s = synd_s ^ SYND_W'(i + 1);
         end else begin
            synd_s = synd_s;
         end
      end
   end

   // Syndromes 13..15 point outside the codeword and are left uncorrected
   always_comb begin
      corr_s  = (synd_s != 4'd0) && (synd_s <= 4'd12);
      fixed_s = code_i;
      if (corr_s) begin
         fixed_s[synd_s - 4'd1] = ~code_i[synd_s - 4'd1];
      end else begin
         fixed_s = code_i;
      end
      data_o = {DATA_W{1'b0}};
      for (int i = 0; i < DATA_W; i++) begin
         data_o[i] = fixed_s[DATA_POS[i] - 4'd1];
      end
   end

   assign code_o   = fixed_s;
   assign synd_o   = synd_s;
   assign corr_o   = corr_s;
   assign uncorr_o = (synd_s >= 4'd13);

endmodule

// File: rtl/hamming_sec_ctrl.sv
// Host front end and background scrubber for the 16x12 Hamming SEC array.
// The scrubber is built only when HAMMING_SEC_SCRUB_EN is defined.
module hamming_sec_ctrl
   import hamming_sec_pkg::*;
#(
   parameter int ADDR_W         = 4,
   parameter int SCRUB_INTERVAL = 256,
   parameter int CNT_W          = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_we,
   input  logic [ADDR_W-1:0]   req_addr,
   input  logic [DATA_W-1:0]   req_wdata,
   output logic                resp_valid,
   output logic [DATA_W-1:0]   resp_rdata,
   output logic                resp_corr,
   output logic                resp_uncorr,
   output logic                mem_wr_en,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [CODE_W-1:0]   mem_wdata,
   input  logic [CODE_W-1:0]   mem_rdata,
   output logic [CNT_W-1:0]    corr_cnt,
   output logic [CNT_W-1:0]    uncorr_cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic [DATA_W-1:0] dec_data_s;
   logic [CODE_W-1:0] dec_code_s;
   logic [SYND_W-1:0] dec_synd_s;
   logic              dec_corr_s, dec_uncorr_s;

   logic              ready_s, wr_s, rd_acc_s, scrub_rd_s;
   logic [ADDR_W-1:0] addr_s;
   logic [CODE_W-1:0] wdata_s;
   logic              unused_s;

   logic              resp_valid_q, resp_valid_d;
   logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
   logic              resp_corr_q, resp_corr_d;
   logic              resp_uncorr_q, resp_uncorr_d;
   logic [CNT_W-1:0]  corr_cnt_q, corr_cnt_d;
   logic [CNT_W-1:0]  uncorr_cnt_q, uncorr_cnt_d;

   hamming_sec_dec u_dec (
      .code_i   (mem_rdata),
      .data_o   (dec_data_s),
      .code_o   (dec_code_s),
      .synd_o   (dec_synd_s),
      .corr_o   (dec_corr_s),
      .uncorr_o (dec_uncorr_s)
   );

`ifdef HAMMING_SEC_SCRUB_EN
   localparam int IV_W = (SCRUB_INTERVAL > 1) ? $clog2(SCRUB_INTERVAL) : 1;
   localparam logic [IV_W-1:0] IV_TERM = IV_W'(SCRUB_INTERVAL - 1);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic [IV_W-1:0]   iv_q, iv_d;
   logic              due_q, due_d;
   logic [CODE_W-1:0] fix_q, fix_d;

   assign unused_s = ^dec_synd_s;

   // Scrub FSM, interval timer and memory-port steering
   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      due_d      = due_q;
      fix_d      = fix_q;
      ready_s    = 1'b0;
      wr_s       = 1'b0;
      rd_acc_s   = 1'b0;
      scrub_rd_s = 1'b0;
      addr_s     = req_addr;
      wdata_s    = hamming_sec_encode(req_wdata);
      if (iv_q == IV_TERM) begin
         iv_d  = {IV_W{1'b0}};
         due_d = 1'b1;
      end else begin
         iv_d  = iv_q + IV_W'(1);
      end
      case (state_q)
         ST_IDLE: begin
            ready_s  = 1'b1;
            wr_s     = req_valid & req_we;
            rd_acc_s = req_valid & ~req_we;
            // Host traffic always wins; a pending scrub starts on the first idle cycle
            if (!req_valid && due_q) begin
               state_d = ST_SCRUB_RD;
               due_d   = 1'b0;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_SCRUB_RD: begin
            addr_s     = ptr_q;
            scrub_rd_s = 1'b1;
            fix_d      = dec_code_s;
            if (dec_corr_s) begin
               state_d = ST_SCRUB_WB;
            end else begin
               state_d = ST_IDLE;
               ptr_d   = ptr_q + ADDR_W'(1);
            end
         end
         ST_SCRUB_WB: begin
            addr_s  = ptr_q;
            wdata_s = fix_q;
            wr_s    = 1'b1;
            ptr_d   = ptr_q + ADDR_W'(1);
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Scrubber state registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         ptr_q   <= {ADDR_W{1'b0}};
         iv_q    <= {IV_W{1'b0}};
         due_q   <= 1'b0;
         fix_q   <= {CODE_W{1'b0}};
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         iv_q    <= iv_d;
         due_q   <= due_d;
         fix_q   <= fix_d;
      end
   end
`else
   assign unused_s = (^dec_code_s) ^ (^dec_synd_s) ^ (SCRUB_INTERVAL == 0);

   // Host-only steering
   always_comb begin
      ready_s    = 1'b1;
      wr_s       = req_valid & req_we;
      rd_acc_s   = req_valid & ~req_we;
      scrub_rd_s = 1'b0;
      addr_s     = req_addr;
      wdata_s    = hamming_sec_encode(req_wdata);
   end
`endif

   // Read response capture and saturating error statistics
   always_comb begin
      resp_valid_d  = rd_acc_s;
      resp_corr_d   = rd_acc_s & dec_corr_s;
      resp_uncorr_d = rd_acc_s & dec_uncorr_s;
      if (rd_acc_s) begin
         resp_rdata_d = dec_data_s;
      end else begin
         resp_rdata_d = resp_rdata_q;
      end
      if ((rd_acc_s | scrub_rd_s) && dec_corr_s && (corr_cnt_q != CNT_MAX)) begin
         corr_cnt_d = corr_cnt_q + CNT_W'(1);
      end else begin
         corr_cnt_d = corr_cnt_q;
      end
      if ((rd_acc_s | scrub_rd_s) && dec_uncorr_s && (uncorr_cnt_q != CNT_MAX)) begin
         uncorr_cnt_d = uncorr_cnt_q + CNT_W'(1);
      end else begin
         uncorr_cnt_d = uncorr_cnt_q;
      end
   end

   // Response and counter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         resp_valid_q  <= 1'b0;
         resp_rdata_q  <= {DATA_W{1'b0}};
         resp_corr_q   <= 1'b0;
         resp_uncorr_q <= 1'b0;
         corr_cnt_q    <= {CNT_W{1'b0}};
         uncorr_cnt_q  <= {CNT_W{1'b0}};
      end else begin
         resp_valid_q  <= resp_valid_d;
         resp_rdata_q  <= resp_rdata_d;
         resp_corr_q   <= resp_corr_d;
         resp_uncorr_q <= resp_uncorr_d;
         corr_cnt_q    <= corr_cnt_d;
         uncorr_cnt_q  <= uncorr_cnt_d;
      end
   end

   // The array port is held quiet while reset is asserted, so an aborted scrub never writes
   assign mem_wr_en   = rst_n & wr_s;
   assign mem_addr    = rst_n ? addr_s  : {ADDR_W{1'b0}};
   assign mem_wdata   = rst_n ? wdata_s : {CODE_W{1'b0}};
   assign req_ready   = ready_s;
   assign resp_valid  = resp_valid_q;
   assign resp_rdata  = resp_rdata_q;
   assign resp_corr   = resp_corr_q;
   assign resp_uncorr = resp_uncorr_q;
   assign corr_cnt    = corr_cnt_q;
   assign uncorr_cnt  = uncorr_cnt_q;

endmodule

// File: tb/tb_hamming_sec_ctrl.sv
// Directed bench for hamming_sec_ctrl with a behavioural 16x12 array; scrub checks need HAMMING_SEC_SCRUB_EN.
module tb_hamming_sec_ctrl;

   localparam int ADDR_W = 4;
   localparam int CNT_W  = 2;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              req_valid = 1'b0;
   logic              req_ready;
   logic              req_we = 1'b0;
   logic [ADDR_W-1:0] req_addr = 4'd0;
   logic [7:0]        req_wdata = 8'd0;
   logic              resp_valid;
   logic [7:0]        resp_rdata;
   logic              resp_corr, resp_uncorr;
   logic              mem_wr_en;
   logic [ADDR_W-1:0] mem_addr;
   logic [11:0]       mem_wdata;
   logic [11:0]       mem_rdata;
   logic [CNT_W-1:0]  corr_cnt, uncorr_cnt;

   logic [11:0] arr [16];
   int n_vec = 0;
   int n_err = 0;

   hamming_sec_ctrl #(.ADDR_W(ADDR_W), .SCRUB_INTERVAL(4), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata),
      .resp_corr(resp_corr), .resp_uncorr(resp_uncorr),
      .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .corr_cnt(corr_cnt), .uncorr_cnt(uncorr_cnt)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_wr_en) arr[mem_addr] <= mem_wdata;
   end
   assign mem_rdata = arr[mem_addr];

   task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      req_valid = 1'b0;
      for (int i = 0; i < 16; i++) arr[i] = 12'h000;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic drive(input logic we, input logic [3:0] a, input logic [7:0] d);
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = a;
      req_wdata = d;
   endtask

   task automatic wait_ready(input logic level, input string tag);
      int n = 0;
      while (req_ready !== level && n < 40) begin
         @(negedge clk);
         n++;
      end
      check_value(tag, req_ready, level);
   endtask

   initial begin
      // Reset state, with a host write request driven to prove mem_wr_en is forced low
      @(negedge clk);
      drive(1'b1, 4'd7, 8'hFF);
      @(negedge clk);
      check_value("rst_wr_en", mem_wr_en, 1'b0);
      check_value("rst_addr", mem_addr, 4'd0);
      check_value("rst_wdata", mem_wdata, 12'h000);
      check_value("rst_resp_valid", resp_valid, 1'b0);
      check_value("rst_rdata", resp_rdata, 8'h00);
      check_value("rst_corr_cnt", corr_cnt, 2'd0);
      check_value("rst_uncorr_cnt", uncorr_cnt, 2'd0);
      req_valid = 1'b0;

      // Host write 0xA5 -> 0xA27, then read back
      do_reset();
      drive(1'b1, 4'd3, 8'hA5);
      #1;
      check_value("wr_wdata", mem_wdata, 12'hA27);
      check_value("wr_en", mem_wr_en, 1'b1);
      check_value("wr_ready", req_ready, 1'b1);
      @(negedge clk);
      check_value("wr_array", arr[3], 12'hA27);
      drive(1'b0, 4'd3, 8'h00);
      #1;
      check_value("rd_no_wr", mem_wr_en, 1'b0);
      @(posedge clk); #1;
      check_value("rd_valid", resp_valid, 1'b1);
      check_value("rd_data", resp_rdata, 8'hA5);
      check_value("rd_corr", resp_corr, 1'b0);
      check_value("rd_uncorr", resp_uncorr, 1'b0);
      @(negedge clk);
      req_valid = 1'b0;
      @(posedge clk); #1;
      check_value("rd_pulse", resp_valid, 1'b0);

      // Write 0xFF encodes to 0xF77
      do_reset();
      drive(1'b1, 4'd9, 8'hFF);
      #1;
      check_value("wr_ff", mem_wdata, 12'hF77);
      @(negedge clk);
      req_valid = 1'b0;

      // Single-bit error corrected on read, no write-back
      do_reset();
      arr[3] = 12'hA07;
      drive(1'b0, 4'd3, 8'h00);
      #1;
      check_value("corr_no_wr", mem_wr_en, 1'b0);
      @(posedge clk); #1;
      check_value("corr_data", resp_rdata, 8'hA5);
      check_value("corr_flag", resp_corr, 1'b1);
      check_value("corr_cnt", corr_cnt, 2'd1);
      @(negedge clk);
      req_valid = 1'b0;
      check_value("corr_array", arr[3], 12'hA07);

      // Syndrome 13: uncorrectable
      do_reset();
      arr[3] = 12'h226;
      drive(1'b0, 4'd3, 8'h00);
      #1;
      check_value("unc_no_wr", mem_wr_en, 1'b0);
      @(posedge clk); #1;
      check_value("unc_flag", resp_uncorr, 1'b1);
      check_value("unc_corr", resp_corr, 1'b0);
      check_value("unc_cnt", uncorr_cnt, 2'd1);
      check_value("unc_corr_cnt", corr_cnt, 2'd0);
      @(negedge clk);
      req_valid = 1'b0;
      check_value("unc_array", arr[3], 12'h226);

      // Back-to-back reads held across scrub expiry; corr_cnt saturates at 3
      do_reset();
      arr[4] = 12'hE77;
      arr[5] = 12'hA27;
      for (int i = 0; i < 10; i++) begin
         drive(1'b0, (i % 2 == 0) ? 4'd4 : 4'd5, 8'h00);
         @(posedge clk); #1;
         check_value("b2b_valid", resp_valid, 1'b1);
         check_value("b2b_data", resp_rdata, (i % 2 == 0) ? 8'hFF : 8'hA5);
         check_value("b2b_ready", req_ready, 1'b1);
         @(negedge clk);
      end
      check_value("sat_corr_cnt", corr_cnt, 2'd3);
      req_valid = 1'b0;
      @(posedge clk); #1;
`ifdef HAMMING_SEC_SCRUB_EN
      check_value("held_scrub_start", req_ready, 1'b0);
      check_value("held_scrub_addr", mem_addr, 4'd0);
`else
      check_value("no_scrub_ready", req_ready, 1'b1);
      check_value("no_scrub_wr", mem_wr_en, 1'b0);
`endif

`ifdef HAMMING_SEC_SCRUB_EN
      // Scrub corrects addr 0, then the pointer walks and wraps
      do_reset();
      arr[0] = 12'hA07;
      wait_ready(1'b0, "scrub_rd_wait");
      check_value("scrub_rd_addr", mem_addr, 4'd0);
      check_value("scrub_rd_wr", mem_wr_en, 1'b0);
      @(negedge clk);
      check_value("scrub_wb_ready", req_ready, 1'b0);
      check_value("scrub_wb_en", mem_wr_en, 1'b1);
      check_value("scrub_wb_addr", mem_addr, 4'd0);
      check_value("scrub_wb_data", mem_wdata, 12'hA27);
      @(negedge clk);
      check_value("scrub_done_ready", req_ready, 1'b1);
      check_value("scrub_array", arr[0], 12'hA27);
      check_value("scrub_corr_cnt", corr_cnt, 2'd1);
      for (int k = 1; k <= 16; k++) begin
         wait_ready(1'b0, "scrub_walk_wait");
         check_value("scrub_walk_addr", mem_addr, 4'(k % 16));
         check_value("scrub_walk_wr", mem_wr_en, 1'b0);
         wait_ready(1'b1, "scrub_walk_idle");
      end

      // Reset during SCRUB_RD with a pending correction aborts the write
      do_reset();
      arr[0] = 12'hA07;
      arr[3] = 12'hA07;
      drive(1'b0, 4'd3, 8'h00);
      @(posedge clk); #1;
      check_value("pre_rst_corr_cnt", corr_cnt, 2'd1);
      @(negedge clk);
      req_valid = 1'b0;
      wait_ready(1'b0, "abort_wait");
      rst_n = 1'b0;
      #1;
      check_value("abort_wr_en", mem_wr_en, 1'b0);
      check_value("abort_ready", req_ready, 1'b1);
      check_value("abort_corr_cnt", corr_cnt, 2'd0);
      @(posedge clk); #1;
      check_value("abort_wr_en2", mem_wr_en, 1'b0);
      @(negedge clk);
      check_value("abort_array", arr[0], 12'hA07);
      rst_n = 1'b1;
      wait_ready(1'b0, "abort_rescrub_wait");
      check_value("abort_ptr", mem_addr, 4'd0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/hamming_sec_ctrl.md
Name: hamming_sec_ctrl

Overview:
Front-end controller for the 16x12 Hamming SEC memory array. It owns the array's wr_en/addr/data_in and consumes its data_out.
- Host side: 8-bit data. Writes are encoded into Hamming(12,8) codewords. Reads are decoded with single-bit correction.
- Background scrubber: walks the array and writes corrected codewords back.

Parameters:
ADDR_W, 4, array address width (depth = 2**ADDR_W).
SCRUB_INTERVAL, 256, cycles between scrub attempts (>= 2).
CNT_W, 8, width of error statistic counters.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
req_valid  in  1  host request present.
req_ready  out  1  controller accepts request this cycle.
req_we  in  1  1 = write, 0 = read.
req_addr  in  ADDR_W  host address.
req_wdata  in  8  host write data.
resp_valid  out  1  read response valid, one-cycle pulse.
resp_rdata  out  8  corrected read data.
resp_corr  out  1  read had a single-bit error that was corrected.
resp_uncorr  out  1  read syndrome 13..15, data unreliable.
mem_wr_en  out  1  to array wr_en.
mem_addr  out  ADDR_W  to array addr.
mem_wdata  out  12  to array data_in.
mem_rdata  in  12  from array data_out (combinational read).
corr_cnt  out  CNT_W  saturating count of corrected errors.
uncorr_cnt  out  CNT_W  saturating count of uncorrectable detections.

Behaviour:
- Codeword layout: bit i holds position i+1. Parity sits at positions 1, 2, 4, 8. Data d[0..7] sits at positions 3, 5, 6, 7, 9, 10, 11, 12.
- Syndrome: 4-bit XOR of the position numbers of all set bits.
  - 0: clean.
  - 1..12: flip that position.
  - 13..15: uncorrectable, no flip.
  - Double errors aliasing to 1..12 are miscorrected; this is the accepted SEC limitation.
- Reset (async, rst_n=0) values:
  - state = IDLE, scrub_ptr = 0, interval counter = 0, scrub_due = 0.
  - resp_* = 0, counters = 0.
  - mem_wr_en forced 0 combinationally while rst_n=0; mem_addr = 0, mem_wdata = 0.
- Reset asserted mid-scrub aborts with no write.
- FSM states: IDLE, SCRUB_RD, SCRUB_WB.
- IDLE:
  - req_ready = 1.
  - mem_addr = req_addr.
  - mem_wdata = encode(req_wdata).
  - mem_wr_en = req_valid & req_we.
- Host write: the array is updated at the same edge the request is accepted. No response.
- Host read: the request is accepted at edge T. Decoded mem_rdata is registered, and resp_valid/resp_rdata/resp_corr/resp_uncorr appear in the cycle after T for exactly one cycle.
  - Host reads do not write back.
  - Back-to-back reads give a response every cycle.
- Interval counter: counts 0..SCRUB_INTERVAL-1 and wraps.
  - Reaching the terminal count sets scrub_due.
  - Further expiries while due do not accumulate.
- IDLE with scrub_due=1 and req_valid=0: go to SCRUB_RD and clear scrub_due. Host has priority; a scrub waits indefinitely while req_valid stays high.
- SCRUB_RD:
  - req_ready = 0, mem_addr = scrub_ptr, mem_rdata is decoded, corrected codeword is registered.
  - Syndrome 1..12: go to SCRUB_WB.
  - Otherwise: scrub_ptr++ and go to IDLE.
- SCRUB_WB:
  - req_ready = 0, mem_wr_en = 1, mem_addr = scrub_ptr, mem_wdata = corrected codeword.
  - Then scrub_ptr++ and go to IDLE.
- scrub_ptr wraps 2**ADDR_W-1 -> 0.
- Counters: corr_cnt++ on each corrected host read or scrub correction; uncorr_cnt++ on each syndrome 13..15. Both saturate at all-ones and never wrap.

Optional Feature:
HAMMING_SEC_SCRUB_EN.
- Defined: scrubber as described.
- Undefined: FSM is IDLE only; no interval counter or scrub_ptr; req_ready is held at 1. Counters count host reads only.

Decomposition:
- Package hamming_sec_pkg holds:
  - DATA_W=8, CODE_W=12, SYND_W=4.
  - Parity/data position constants.
  - State enum.
  - Pure function hamming_sec_encode(data) -> codeword.
- Sub-module hamming_sec_dec: combinational codeword -> {data, corrected codeword, syndrome, corr, uncorr}. Instantiated once and shared between the host read path and SCRUB_RD, since the two are never active in the same cycle.

Test Plan:
- Write addr 3 data 0xA5 -> mem_wdata=0xA27 with mem_wr_en=1 for one cycle; read addr 3 -> next cycle resp_rdata=0xA5, resp_corr=0, resp_uncorr=0.
- Backdoor array[3]=0xA07 (position 6 flipped), host read -> resp_rdata=0xA5, resp_corr=1, corr_cnt=1, array still 0xA07.
- Backdoor array[3]=0x226 (positions 1 and 12 flipped, syndrome 13), read -> resp_uncorr=1, uncorr_cnt=1, no write-back.
- Scrub with SCRUB_INTERVAL=4, array[0]=0xA07 -> SCRUB_RD then SCRUB_WB write 0xA27 to addr 0, scrub_ptr=1; after 16 scrubs ptr wraps to 0.
- Hold req_valid=1 across scrub expiry -> no scrub until req_valid drops, then SCRUB_RD next cycle; req_ready=0 during scrub states.
- Assert rst_n low during SCRUB_RD with pending correction -> mem_wr_en stays 0, state IDLE, counters and ptr 0.
